// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares a 2:1 mux between two valid/ready requesters and
// registers the result into a one-entry output stage. Optional grant counters: MUX_ARB_STATS_EN.
module mux_rr_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic             sel,
   output logic [WIDTH-1:0] z,
   output logic             z_valid,
`ifdef MUX_ARB_STATS_EN
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
`endif
   input  logic             z_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;
   logic   last;
   logic   free;
   logic   grant_a;
   logic   grant_b;
   logic   transfer;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("mux_rr_arbiter: CNT_W must be at least 1");
   end

   assign z_valid = (state == FULL);

   // NOTE: reset gates the readys combinationally so no requester sees an accept while the stage is being cleared.
   assign free     = !reset && (!z_valid || z_ready);
   assign grant_a  = a_valid && (!b_valid || last);
   assign grant_b  = b_valid && (!a_valid || !last);
   assign sel      = grant_a ? 1'b0 : (grant_b ? 1'b1 : last);
   assign a_ready  = free && grant_a;
   assign b_ready  = free && grant_b;
   assign transfer = free && (a_valid || b_valid);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
         z     <= '0;
         last  <= 1'b1;
      end else if (transfer) begin
         state <= FULL;
         z     <= sel ? b_data : a_data;
         last  <= sel;
      end else if (z_ready) begin
         // Drain with nothing to replace it: data is left as-is, only the flag drops.
         state <= EMPTY;
      end
   end

`ifdef MUX_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (a_ready) cnt_a <= cnt_a + CNT_W'(1);
         if (b_ready) cnt_b <= cnt_b + CNT_W'(1);
      end
   end
`endif

endmodule
